// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM state
// encoding, opcodes, ALU operation codes and datapath select encodings.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECUTEI = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   // Immediate format implied by the opcode; unknown opcodes fall back to I.
   function automatic logic [1:0] imm_src_for(input logic [6:0] op);
      case (op)
         OP_SW:     return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp request plus instruction fields onto the
// 3-bit ALUControl code consumed directly by the ALU.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [2:0] funct3,
   input  logic       op5,
   input  logic       funct7b5,
   output logic [2:0] ALUControl
);

   // Subtraction only for R-type with funct7[5] set; addi never subtracts.
   always_comb begin
      ALUControl = ALUC_ADD;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALUC_ADD;
         ALUOP_SUB: ALUControl = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000:  ALUControl = (op5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
               3'b010:  ALUControl = ALUC_SLT;
               3'b110:  ALUControl = ALUC_OR;
               3'b111:  ALUControl = ALUC_AND;
               default: ALUControl = ALUC_ADD;
            endcase
         end
         default: ALUControl = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control unit: Moore main FSM, ImmSrc decode and ALU
// decoder instance. Optional macro CONTROLLER_BNE_EN adds bne support
// (branch condition becomes Zero XOR funct3[0]).
//
// state     | meaning
// ----------+----------------------------------------------------
// FETCH     | read instruction, latch IR/OldPC, PC <= PC + 4
// DECODE    | read registers, precompute branch/jump target
// MEMADR    | compute load/store address rs1 + imm
// MEMREAD   | read data memory at ALUOut
// MEMWB     | write loaded data to rd
// MEMWRITE  | write rs2 to data memory at ALUOut
// EXECUTER  | R-type ALU operation on rs1, rs2
// ALUWB     | write ALUOut to rd
// EXECUTEI  | I-type ALU operation on rs1, imm
// JAL       | PC <= target, ALU forms return address OldPC + 4
// BEQ       | compare rs1 - rs2, redirect PC when taken
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic       Illegal,
   output logic [3:0] State
);

   state_t     state_q;
   state_t     state_next;

   logic       pc_update;
   logic       branch;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] result_src;
   logic [1:0] src_a;
   logic [1:0] src_b;
   logic [1:0] alu_op;
   logic [2:0] alu_control;
   logic       decode_illegal;
   logic       branch_cond;
   logic       branch_legal;

`ifdef CONTROLLER_BNE_EN
   assign branch_cond  = Zero ^ funct3[0];
   assign branch_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
   assign branch_cond  = Zero;
   assign branch_legal = 1'b1;
`endif

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_next;
   end

   // Next-state selection; an unsupported opcode returns straight to FETCH.
   always_comb begin
      state_next     = state_q;
      decode_illegal = 1'b0;
      case (state_q)
         S_FETCH: state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_R:         state_next = S_EXECUTER;
               OP_I:         state_next = S_EXECUTEI;
               OP_JAL:       state_next = S_JAL;
               OP_BRANCH: begin
                  if (branch_legal) begin
                     state_next = S_BEQ;
                  end else begin
                     state_next     = S_FETCH;
                     decode_illegal = 1'b1;
                  end
               end
               default: begin
                  state_next     = S_FETCH;
                  decode_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWRITE: state_next = S_FETCH;
         S_EXECUTER: state_next = S_ALUWB;
         S_EXECUTEI: state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_JAL:      state_next = S_ALUWB;
         S_BEQ:      state_next = S_FETCH;
         default:    state_next = S_FETCH;
      endcase
   end

   // Moore output decode; anything a state does not name stays 0.
   always_comb begin
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      result_src = RES_ALUOUT;
      src_a      = SRCA_PC;
      src_b      = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            src_b      = SRCB_FOUR;
            result_src = RES_ALURESULT;
            pc_update  = 1'b1;
         end
         S_DECODE: begin
            src_a = SRCA_OLDPC;
            src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            src_a = SRCA_RS1;
            src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            src_a  = SRCA_RS1;
            src_b  = SRCB_RS2;
            alu_op = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            src_a  = SRCA_RS1;
            src_b  = SRCB_IMM;
            alu_op = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_JAL: begin
            src_a     = SRCA_OLDPC;
            src_b     = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_BEQ: begin
            src_a  = SRCA_RS1;
            src_b  = SRCB_RS2;
            alu_op = ALUOP_SUB;
            branch = 1'b1;
         end
         default: ;
      endcase
   end

   alu_decoder u_alu_decoder (
      .ALUOp      (alu_op),
      .funct3     (funct3),
      .op5        (op[5]),
      .funct7b5   (funct7b5),
      .ALUControl (alu_control)
   );

   // While reset is held every strobe and select is quiet, so nothing in the
   // datapath can be written during or right after an aborted instruction.
   always_comb begin
      if (reset) begin
         PCWrite    = 1'b0;
         AdrSrc     = 1'b0;
         MemWrite   = 1'b0;
         IRWrite    = 1'b0;
         RegWrite   = 1'b0;
         ResultSrc  = 2'b00;
         ALUSrcA    = 2'b00;
         ALUSrcB    = 2'b00;
         ImmSrc     = 2'b00;
         ALUControl = 3'b000;
         Illegal    = 1'b0;
      end else begin
         PCWrite    = pc_update | (branch & branch_cond);
         AdrSrc     = adr_src;
         MemWrite   = mem_write;
         IRWrite    = ir_write;
         RegWrite   = reg_write;
         ResultSrc  = result_src;
         ALUSrcA    = src_a;
         ALUSrcB    = src_b;
         ImmSrc     = imm_src_for(op);
         ALUControl = alu_control;
         Illegal    = decode_illegal;
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// hand-derived output vector expected for each cycle, a monitor compares it
// against the DUT mid-cycle.
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0] ALUControl;
   logic [3:0] State;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [2:0] aluc;
      logic       ill;
   } ov_t;

   ov_t exp_q[$];
   int  id_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  failures = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (zero),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .Illegal    (Illegal),
      .State      (State)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hand table of the fixed outputs in each state (ImmSrc and the
   // input-dependent fields are filled in by the caller).
   function automatic ov_t base(input int s);
      ov_t e;
      e    = '0;
      e.st = s[3:0];
      case (s)
         0:  begin e.pcw = 1'b1; e.irw = 1'b1; e.res = 2'b10; e.sb = 2'b10; end
         1:  begin e.sa = 2'b01; e.sb = 2'b01; end
         2:  begin e.sa = 2'b10; e.sb = 2'b01; end
         3:  begin e.adr = 1'b1; end
         4:  begin e.res = 2'b01; e.rw = 1'b1; end
         5:  begin e.adr = 1'b1; e.mw = 1'b1; end
         6:  begin e.sa = 2'b10; e.sb = 2'b00; end
         7:  begin e.rw = 1'b1; end
         8:  begin e.sa = 2'b10; e.sb = 2'b01; end
         9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
         10: begin e.sa = 2'b10; e.sb = 2'b00; e.aluc = 3'b001; end
         default: ;
      endcase
      return e;
   endfunction

   function automatic string fmt(input ov_t v);
      return $sformatf("st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%b sa=%b sb=%b imm=%b aluc=%b ill=%b",
                       v.st, v.pcw, v.adr, v.mw, v.irw, v.rw, v.res, v.sa, v.sb, v.imm, v.aluc, v.ill);
   endfunction

   task automatic push(input ov_t e);
      exp_q.push_back(e);
      id_q.push_back(cyc);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int s, input logic [1:0] imm, input logic [2:0] al,
                       input logic pcw, input logic ill);
      ov_t e;
      e     = base(s);
      e.imm = imm;
      if (s == 6 || s == 8 || s == 10) e.aluc = al;
      if (s == 10) e.pcw = pcw;
      if (s == 1)  e.ill = ill;
      reset = 1'b0;
      push(e);
   endtask

   task automatic rst_step(input int s);
      ov_t e;
      e     = '0;
      e.st  = s[3:0];
      reset = 1'b1;
      push(e);
   endtask

   task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      zero     = z;
   endtask

   // R-type / I-ALU: FETCH, DECODE, EXECUTE(R or I), ALUWB.
   task automatic alu_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int xs, input logic [2:0] al);
      set_in(o, f3, f7, z);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);
      step(1, 2'b00, 3'b000, 1'b0, 1'b0);
      step(xs, 2'b00, al, 1'b0, 1'b0);
      step(7, 2'b00, 3'b000, 1'b0, 1'b0);
   endtask

   task automatic branch_instr(input logic [2:0] f3, input logic z, input logic pcw);
      set_in(7'b1100011, f3, 1'b0, z);
      step(0, 2'b10, 3'b000, 1'b0, 1'b0);
      step(1, 2'b10, 3'b000, 1'b0, 1'b0);
      step(10, 2'b10, 3'b001, pcw, 1'b0);
   endtask

   // Monitor: compare whenever an expectation is pending for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ov_t e, a;
         int  id;
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         a  = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL cyc%0d got {%s} expected {%s}", id, fmt(a), fmt(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_in(7'b0110011, 3'b000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      // Reset held: quiet outputs in FETCH.
      rst_step(0);
      rst_step(0);
      rst_step(0);
      // add, then sub, with Zero high to show it is ignored outside BEQ.
      alu_instr(7'b0110011, 3'b000, 1'b0, 1'b1, 6, 3'b000);
      alu_instr(7'b0110011, 3'b000, 1'b1, 1'b1, 6, 3'b001);
      // addi with funct7b5 set still adds.
      alu_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 8, 3'b000);
      alu_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 6, 3'b101);
      alu_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 8, 3'b110);
      alu_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 6, 3'b010);
      alu_instr(7'b0110011, 3'b001, 1'b0, 1'b0, 6, 3'b000);
      // lw
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);
      step(1, 2'b00, 3'b000, 1'b0, 1'b0);
      step(2, 2'b00, 3'b000, 1'b0, 1'b0);
      step(3, 2'b00, 3'b000, 1'b0, 1'b0);
      step(4, 2'b00, 3'b000, 1'b0, 1'b0);
      // sw
      set_in(7'b0100011, 3'b010, 1'b0, 1'b1);
      step(0, 2'b01, 3'b000, 1'b0, 1'b0);
      step(1, 2'b01, 3'b000, 1'b0, 1'b0);
      step(2, 2'b01, 3'b000, 1'b0, 1'b0);
      step(5, 2'b01, 3'b000, 1'b0, 1'b0);
      // jal
      set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
      step(0, 2'b11, 3'b000, 1'b0, 1'b0);
      step(1, 2'b11, 3'b000, 1'b0, 1'b0);
      step(9, 2'b11, 3'b000, 1'b0, 1'b0);
      step(7, 2'b11, 3'b000, 1'b0, 1'b0);
      // beq taken / not taken
      branch_instr(3'b000, 1'b1, 1'b1);
      branch_instr(3'b000, 1'b0, 1'b0);
`ifdef CONTROLLER_BNE_EN
      branch_instr(3'b001, 1'b1, 1'b0);
      branch_instr(3'b001, 1'b0, 1'b1);
      // blt is not supported when bne is enabled.
      set_in(7'b1100011, 3'b100, 1'b0, 1'b1);
      step(0, 2'b10, 3'b000, 1'b0, 1'b0);
      step(1, 2'b10, 3'b000, 1'b0, 1'b1);
`else
      branch_instr(3'b001, 1'b1, 1'b1);
      branch_instr(3'b001, 1'b0, 1'b0);
      branch_instr(3'b100, 1'b1, 1'b1);
`endif
      // Illegal opcode: pulse in DECODE, then straight back to FETCH.
      set_in(7'b1111111, 3'b000, 1'b0, 1'b1);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);
      step(1, 2'b00, 3'b000, 1'b0, 1'b1);
      // Reset in MEMREAD of a lw: no MEMWB, FETCH next.
      set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);
      step(1, 2'b00, 3'b000, 1'b0, 1'b0);
      step(2, 2'b00, 3'b000, 1'b0, 1'b0);
      rst_step(3);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);
      step(1, 2'b00, 3'b000, 1'b0, 1'b0);
      step(2, 2'b00, 3'b000, 1'b0, 1'b0);
      step(3, 2'b00, 3'b000, 1'b0, 1'b0);
      step(4, 2'b00, 3'b000, 1'b0, 1'b0);
      step(0, 2'b00, 3'b000, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
